// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared defaults and types for the register-file writeback arbiter.
package rf_ctrl_pkg;

    // Index width that stays at least one bit for degenerate sizes.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DEF_NUM_REQ   = 3;
    localparam int unsigned DEF_DATA_W    = 32;
    localparam int unsigned DEF_REG_COUNT = 32;
    localparam int unsigned DEF_ADDR_W    = idx_w(DEF_REG_COUNT);

    typedef logic [idx_w(DEF_NUM_REQ)-1:0] req_idx_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus: per-requester valid/addr/data with one-hot ready back.
interface regfile_wb_arbiter_if
    import rf_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;

    modport master (output req_valid, req_addr, req_data, input req_ready);
    modport slave  (input req_valid, req_addr, req_data, output req_ready);
endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin picker: first requester at or after ptr (modulo NUM_REQ) wins.
module rr_arbiter
    import rf_ctrl_pkg::*;
#(
    parameter  int unsigned NUM_REQ = DEF_NUM_REQ,
    localparam int unsigned IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);
    logic [NUM_REQ-1:0] rot;
    logic [NUM_REQ-1:0] pick;

    // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        rot   = NUM_REQ'({req, req} >> ptr);
        pick  = rot & (-rot);
        grant = NUM_REQ'(({pick, pick} << ptr) >> NUM_REQ);
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates writeback requesters onto a single registered register-file write port.
module regfile_wb_arbiter
    import rf_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned REG_COUNT = DEF_REG_COUNT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    regfile_wb_arbiter_if.slave  wb,
    output logic                 rf_we,
    output logic [REG_COUNT-1:0] rf_wr_sel,
    output logic [DATA_W-1:0]    rf_data,
    output logic [15:0]          wr_count
);
    localparam int unsigned ADDR_W = idx_w(REG_COUNT);
    localparam int unsigned IDX_W  = idx_w(NUM_REQ);

    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   ptr_nxt;
    logic [IDX_W-1:0]   gnt_idx;
    logic [NUM_REQ-1:0] grant;
    logic [ADDR_W-1:0]  gnt_addr;
    logic [DATA_W-1:0]  gnt_data;
    logic               xfer;
    logic               commit;

    logic [ADDR_W-1:0][NUM_REQ-1:0] addr_col;
    logic [DATA_W-1:0][NUM_REQ-1:0] data_col;
    logic [IDX_W-1:0][NUM_REQ-1:0]  idx_col;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req   (wb.req_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    assign wb.req_ready = (reset && !stall) ? grant : '0;

    // One-hot AND-OR selection, built bit-column-wise so every index is constant.
    for (genvar r = 0; r < NUM_REQ; r++) begin : g_req
        for (genvar b = 0; b < ADDR_W; b++) begin : g_addr
            assign addr_col[b][r] = grant[r] & wb.req_addr[r*ADDR_W + b];
        end
        for (genvar b = 0; b < DATA_W; b++) begin : g_data
            assign data_col[b][r] = grant[r] & wb.req_data[r*DATA_W + b];
        end
        for (genvar b = 0; b < IDX_W; b++) begin : g_idx
            assign idx_col[b][r] = grant[r] & (((r >> b) & 1) != 0);
        end
    end

    for (genvar b = 0; b < ADDR_W; b++) begin : g_addr_or
        assign gnt_addr[b] = |addr_col[b];
    end
    for (genvar b = 0; b < DATA_W; b++) begin : g_data_or
        assign gnt_data[b] = |data_col[b];
    end
    for (genvar b = 0; b < IDX_W; b++) begin : g_idx_or
        assign gnt_idx[b] = |idx_col[b];
    end

    // Register 0 and out-of-range indices are accepted but never written.
    always_comb begin
        xfer    = |wb.req_ready;
        commit  = xfer && (gnt_addr != '0) && (32'(gnt_addr) < REG_COUNT);
        ptr_nxt = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr       <= '0;
            rf_we     <= 1'b0;
            rf_wr_sel <= '0;
            rf_data   <= '0;
            wr_count  <= '0;
        end else begin
            rf_we     <= commit;
            rf_wr_sel <= commit ? (REG_COUNT'(1) << gnt_addr) : '0;
            if (commit) begin
                rf_data  <= gnt_data;
                wr_count <= wr_count + 16'd1;
            end
            if (xfer) begin
                ptr <= ptr_nxt;
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a behavioural model.
module tb_regfile_wb_arbiter;
    import rf_ctrl_pkg::*;

    localparam int NR = 3;
    localparam int DW = 32;
    localparam int RC = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall;
    logic          rf_we;
    logic [RC-1:0] rf_wr_sel;
    logic [DW-1:0] rf_data;
    logic [15:0]   wr_count;

    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) wb();

    regfile_wb_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .REG_COUNT(RC)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .stall     (stall),
        .wb        (wb),
        .rf_we     (rf_we),
        .rf_wr_sel (rf_wr_sel),
        .rf_data   (rf_data),
        .wr_count  (wr_count)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference state: rotating priority start, last write-port values, commit count.
    int            m_ptr;
    logic          m_we;
    logic [RC-1:0] m_sel;
    logic [DW-1:0] m_data;
    int unsigned   m_count;

    function automatic void model_reset();
        m_ptr   = 0;
        m_we    = 1'b0;
        m_sel   = '0;
        m_data  = '0;
        m_count = 0;
    endfunction

    function automatic int exp_grant();
        if (!rst_n || stall) return -1;
        for (int k = 0; k < NR; k++) begin
            int idx;
            idx = (m_ptr + k) % NR;
            if (wb.req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [NR-1:0] v);
        int hit;
        int n;
        hit = -1;
        n   = 0;
        for (int i = 0; i < NR; i++) begin
            if (v[i]) begin
                hit = i;
                n++;
            end
        end
        return (n == 1) ? hit : -1;
    endfunction

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wb.req_valid[i]         = v;
        wb.req_addr[i*AW +: AW] = a;
        wb.req_data[i*DW +: DW] = d;
    endtask

    task automatic new_req(input int i, input logic v);
        logic [AW-1:0] a;
        a = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, RC - 1));
        set_req(i, v, a, $urandom);
    endtask

    // One clock: check ready before the edge, advance the model, check registered outputs.
    task automatic cycle(output int g);
        logic [NR-1:0] er;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        a = '0;
        d = '0;
        #1;
        g  = exp_grant();
        er = (g < 0) ? '0 : (NR'(1) << g);
        check("req_ready", wb.req_ready, er);
        if (g >= 0) begin
            a = wb.req_addr[g*AW +: AW];
            d = wb.req_data[g*DW +: DW];
        end
        @(posedge clk);
        #1;
        if (g >= 0 && a != 0 && int'(a) < RC) begin
            m_we    = 1'b1;
            m_sel   = RC'(1) << a;
            m_data  = d;
            m_count = (m_count + 1) % 65536;
        end else begin
            m_we  = 1'b0;
            m_sel = '0;
        end
        if (g >= 0) m_ptr = (g + 1) % NR;
        check("rf_we", rf_we, m_we);
        check("rf_wr_sel", rf_wr_sel, m_sel);
        check("rf_data", rf_data, m_data);
        check("wr_count", wr_count, m_count);
        @(negedge clk);
    endtask

    task automatic tick();
        int g;
        cycle(g);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int g;
        rst_n = 1'b0;
        stall = 1'b0;
        wb.req_valid = '0;
        wb.req_addr  = '0;
        wb.req_data  = '0;
        model_reset();

        @(negedge clk);
        set_req(0, 1'b1, 5'd5, 32'h1);
        #1;
        check("rst_ready", wb.req_ready, 3'b000);
        check("rst_we", rf_we, 1'b0);
        check("rst_sel", rf_wr_sel, 32'h0);
        check("rst_count", wr_count, 16'h0);
        @(negedge clk);
        wb.req_valid = '0;
        rst_n = 1'b1;

        repeat (4) tick();
        check("idle_we", rf_we, 1'b0);
        check("idle_sel", rf_wr_sel, 32'h0);
        check("idle_count", wr_count, 16'h0);
        check("idle_ready", wb.req_ready, 3'b000);

        set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
        #1;
        check("single_ready", wb.req_ready, 3'b001);
        tick();
        wb.req_valid[0] = 1'b0;
        check("single_we", rf_we, 1'b1);
        check("single_sel", rf_wr_sel, 32'h0000_0020);
        check("single_data", rf_data, 32'hDEADBEEF);
        check("single_count", wr_count, 16'd1);

        set_req(1, 1'b1, 5'd0, 32'h1234);
        #1;
        check("x0_ready", wb.req_ready, 3'b010);
        tick();
        wb.req_valid[1] = 1'b0;
        check("x0_we", rf_we, 1'b0);
        check("x0_sel", rf_wr_sel, 32'h0);
        check("x0_count", wr_count, 16'd1);

        set_req(2, 1'b1, 5'd7, 32'hCAFE0007);
        stall = 1'b1;
        repeat (3) begin
            #1;
            check("stall_ready", wb.req_ready, 3'b000);
            tick();
        end
        stall = 1'b0;
        #1;
        check("unstall_ready", wb.req_ready, 3'b100);
        tick();
        wb.req_valid[2] = 1'b0;
        check("unstall_we", rf_we, 1'b1);
        check("unstall_count", wr_count, 16'd2);
        tick();
        check("unstall_once", rf_we, 1'b0);
        check("unstall_count2", wr_count, 16'd2);

        set_req(0, 1'b1, 5'd1, 32'hA0);
        set_req(1, 1'b1, 5'd2, 32'hA1);
        set_req(2, 1'b1, 5'd3, 32'hA2);
        for (int k = 0; k < 6; k++) begin
            #1;
            check("rr_order", onehot_idx(wb.req_ready), k % 3);
            tick();
            check("rr_sel", rf_wr_sel, RC'(1) << (k % 3 + 1));
        end
        wb.req_valid = '0;
        check("rr_count", wr_count, 16'd8);

        set_req(0, 1'b1, 5'd9, 32'h99);
        tick();
        wb.req_valid = '0;
        check("pre_rst_we", rf_we, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_rst_we", rf_we, 1'b0);
        check("async_rst_sel", rf_wr_sel, 32'h0);
        check("async_rst_count", wr_count, 16'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        set_req(0, 1'b1, 5'd4, 32'h44);
        set_req(1, 1'b1, 5'd6, 32'h66);
        #1;
        check("post_rst_ready", wb.req_ready, 3'b001);
        tick();
        wb.req_valid[0] = 1'b0;
        tick();
        wb.req_valid[1] = 1'b0;
        check("post_rst_count", wr_count, 16'd2);

        // Requesters hold a pending request until it is taken, then may issue a new one.
        for (int c = 0; c < 400; c++) begin
            stall = ($urandom_range(0, 4) == 0);
            cycle(g);
            if (g >= 0) new_req(g, 1'($urandom_range(0, 1)));
            for (int i = 0; i < NR; i++) begin
                if (!wb.req_valid[i] && $urandom_range(0, 2) == 0) new_req(i, 1'b1);
            end
        end
        stall = 1'b0;
        wb.req_valid = '0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, number of writeback requesters.
REQ-002 SHALL have parameter DATA_W, default 32, register data width.
REQ-003 SHALL have parameter REG_COUNT, default 32, number of registers; ADDR_W = clog2(REG_COUNT).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port stall  input  1  freezes new grants while high.
REQ-007 SHALL have port req_valid  input  NUM_REQ  per-requester write request.
REQ-008 SHALL have port req_addr  input  NUM_REQ*ADDR_W  packed destination register indices; requester i in slice i.
REQ-009 SHALL have port req_data  input  NUM_REQ*DATA_W  packed write data.
REQ-010 SHALL have port req_ready  output  NUM_REQ  one-hot acceptance, combinational.
REQ-011 SHALL have port rf_we  output  1  registered register-file write enable.
REQ-012 SHALL have port rf_wr_sel  output  REG_COUNT  registered one-hot register select.
REQ-013 SHALL have port rf_data  output  DATA_W  registered write data.
REQ-014 SHALL have port wr_count  output  16  registered count of committed writes, wraps.

Function
REQ-015 A transfer SHALL occur on a rising edge where req_valid[i] and req_ready[i] are both 1.
REQ-016 req_ready SHALL be at most one-hot, all-zero when stall=1, reset=0, or req_valid=0.
REQ-017 Grant SHALL be round-robin: search starts at index ptr, wraps modulo NUM_REQ; first valid requester wins.
REQ-018 After a transfer by requester g, ptr SHALL become (g+1) mod NUM_REQ; otherwise ptr holds.
REQ-019 Requesters SHALL hold req_valid, req_addr, req_data stable until transfer; the block SHALL not rely on de-assertion without transfer.
REQ-020 On a transfer with addr != 0: next cycle rf_we=1, rf_wr_sel=1<<addr, rf_data=granted data; latency exactly one cycle, write committed at the falling edge of that cycle by the register bank.
REQ-021 On a transfer with addr == 0: transfer SHALL complete (ready asserted), but rf_we=0, rf_wr_sel=0, wr_count unchanged.
REQ-022 On a cycle without a committed write, rf_we SHALL be 0 and rf_wr_sel SHALL be 0; rf_data holds its previous value.
REQ-023 wr_count SHALL increment by 1 on each cycle rf_we becomes 1 (i.e. per non-x0 transfer), wrapping 0xFFFF -> 0x0000.
REQ-024 Sustained throughput SHALL be one transfer per cycle; no bubble between back-to-back grants.
REQ-025 stall rising during a pending request SHALL block the transfer; rf outputs of the prior transfer still appear the following cycle.
REQ-026 Out-of-range addr (>= REG_COUNT when REG_COUNT not a power of 2) SHALL be treated like addr 0 (accepted, dropped).

Reset
REQ-027 While reset=0: rf_we=0, rf_wr_sel=0, rf_data=0, wr_count=0, ptr=0, req_ready=0, asynchronously.
REQ-028 Reset asserted mid-transfer SHALL discard the in-flight write (rf_we drops immediately); first grant after release starts from requester 0.

Structure
REQ-029 Package rf_ctrl_pkg SHALL hold NUM_REQ, DATA_W, REG_COUNT, ADDR_W defaults and the requester index typedef.
REQ-030 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req vector, ptr; output one-hot grant); pointer and output registers live in the top.

Verification
REQ-031 Reset release, all valid low 4 cycles -> rf_we=0, rf_wr_sel=0, wr_count=0, req_ready=0.
REQ-032 Req0 addr 5 data 0xDEADBEEF alone -> ready[0]=1 same cycle; next cycle rf_we=1, rf_wr_sel=0x00000020, rf_data=0xDEADBEEF, wr_count=1.
REQ-033 All three valid held 6 cycles, addrs 1/2/3 -> grant order 0,1,2,0,1,2; rf_wr_sel 0x2,0x4,0x8 repeating; wr_count=6.
REQ-034 Req1 addr 0 data 0x1234 -> ready[1]=1, next cycle rf_we=0, rf_wr_sel=0, wr_count unchanged.
REQ-035 Req2 valid with stall=1 for 3 cycles then stall=0 -> ready[2]=0 for 3 cycles, then 1; one write only.
REQ-036 reset pulled low the cycle after an accepted write -> rf_we=0 immediately; after release, req0 and req1 valid -> req0 granted first.
